pc_fetch_gen: RTL

Parametrised program-counter and instruction-fetch front end for the RISC-V pipeline. Generates sequential fetch addresses and applies prioritised redirects from any number of later stages. Issues fetch requests over a valid/ready handshake with bounded outstanding requests and drops stale responses by epoch tagging. Buffers returned instructions so that IF/ID stalls never lose data.

---
 rtl/pc_fetch_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_gen.sv
// PC generator and instruction-fetch front end: sequential fetch with prioritised
// redirects, epoch-tagged outstanding requests and a show-ahead instruction buffer.
module pc_fetch_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                INST_BYTES = 4,
  parameter int                NUM_REDIR  = 2,
  parameter int                MAX_OUT    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [5:0]                  stall,
  input  logic [NUM_REDIR-1:0]        redir_valid_i,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_addr_i,
  output logic                        req_valid_o,
  output logic [ADDR_W-1:0]           req_addr_o,
  input  logic                        req_ready_i,
  input  logic                        rsp_valid_i,
  input  logic [31:0]                 rsp_inst_i,
  output logic                        inst_valid_o,
  output logic [31:0]                 inst_o,
  output logic [ADDR_W-1:0]           inst_pc_o,
  output logic [ADDR_W-1:0]           redir_taken_o,
  output logic                        proto_err_o
);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUT - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              epoch_q, epoch_d;
  logic [PTR_W-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CNT_W-1:0]  tag_cnt_q, tag_cnt_d;
  logic [PTR_W-1:0]  buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [CNT_W-1:0]  buf_cnt_q, buf_cnt_d;
  logic              proto_err_q, proto_err_d;

  logic [ADDR_W-1:0] tag_addr_mem  [MAX_OUT];
  logic              tag_epoch_mem [MAX_OUT];
  logic [ADDR_W-1:0] buf_addr_mem  [MAX_OUT];
  logic [31:0]       buf_inst_mem  [MAX_OUT];

  logic [ADDR_W-1:0] redir_addr_arr [NUM_REDIR];
  logic [ADDR_W-1:0] redir_tgt;
  logic              redir_any;
  logic [CNT_W:0]    occ;
  logic              accept, rsp_pop, rsp_keep, buf_pop;
  logic              unused_stall_bits;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REDIR; gi++) begin : g_redir_slice
      assign redir_addr_arr[gi] = redir_addr_i[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Scan from the lowest-priority source so the lowest set index overrides.
  always_comb begin
    redir_tgt = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (redir_valid_i[k]) redir_tgt = redir_addr_arr[k];
    end
  end

  assign redir_any         = |redir_valid_i;
  assign occ               = {1'b0, tag_cnt_q} + {1'b0, buf_cnt_q};
  assign req_valid_o       = !rst && !stall[0] && !redir_any && (occ < (CNT_W+1)'(MAX_OUT));
  assign req_addr_o        = pc_q;
  assign redir_taken_o     = pc_q;
  assign accept            = req_valid_o && req_ready_i;
  assign rsp_pop           = rsp_valid_i && (tag_cnt_q != '0);
  assign rsp_keep          = rsp_pop && (tag_epoch_mem[tag_rd_q] == epoch_q) && !redir_any;
  assign inst_valid_o      = (buf_cnt_q != '0);
  assign buf_pop           = inst_valid_o && !stall[1];
  assign inst_o            = inst_valid_o ? buf_inst_mem[buf_rd_q] : '0;
  assign inst_pc_o         = inst_valid_o ? buf_addr_mem[buf_rd_q] : '0;
  assign proto_err_o       = proto_err_q;
  assign unused_stall_bits = ^stall[5:2];

  always_comb begin
    pc_d        = pc_q;
    epoch_d     = epoch_q;
    tag_wr_d    = accept  ? ptr_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d    = rsp_pop ? ptr_inc(tag_rd_q) : tag_rd_q;
    tag_cnt_d   = tag_cnt_q + CNT_W'(accept) - CNT_W'(rsp_pop);
    buf_wr_d    = rsp_keep ? ptr_inc(buf_wr_q) : buf_wr_q;
    buf_rd_d    = buf_pop  ? ptr_inc(buf_rd_q) : buf_rd_q;
    buf_cnt_d   = buf_cnt_q + CNT_W'(rsp_keep) - CNT_W'(buf_pop);
    proto_err_d = proto_err_q || (rsp_valid_i && (tag_cnt_q == '0));
    if (redir_any) begin
      // Stale tags stay in flight; the epoch flip makes their responses drop.
      pc_d      = redir_tgt;
      epoch_d   = !epoch_q;
      buf_wr_d  = '0;
      buf_rd_d  = '0;
      buf_cnt_d = '0;
    end else if (accept) begin
      pc_d = pc_q + ADDR_W'(INST_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_VEC;
      epoch_q     <= 1'b0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      tag_cnt_q   <= '0;
      buf_wr_q    <= '0;
      buf_rd_q    <= '0;
      buf_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      epoch_q     <= epoch_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      tag_cnt_q   <= tag_cnt_d;
      buf_wr_q    <= buf_wr_d;
      buf_rd_q    <= buf_rd_d;
      buf_cnt_q   <= buf_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tag_addr_mem[tag_wr_q]  <= pc_q;
      tag_epoch_mem[tag_wr_q] <= epoch_q;
    end
    if (rsp_keep) begin
      buf_addr_mem[buf_wr_q] <= tag_addr_mem[tag_rd_q];
      buf_inst_mem[buf_wr_q] <= rsp_inst_i;
    end
  end
endmodule
